// File: rtl/mult_accumulator.sv
// Batch accumulator for a SIZE-bit multiplier: sums COUNT products {cout,out}, then holds the result until the consumer takes it.
// Optional feature: define MULT_ACC_SATURATE_EN to clamp the sum at 2^ACC_W-1 instead of wrapping.
module mult_accumulator #(
    parameter int SIZE  = 4,
    parameter int ACC_W = 8,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SIZE-1:0]  prod_out,
    input  logic             prod_cout,
    input  logic             prod_ovf,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sticky_ovf,
    output logic             acc_carry
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               sticky_reg, sticky_next;
    logic               carry_reg, carry_next;

    logic               accept;
    logic [ACC_W:0]     product_ext;
    logic [ACC_W:0]     sum;
    logic [ACC_W-1:0]   add_value;

    // ACC_W >= SIZE+1, so the zero-extension field is never empty.
    assign product_ext = {{(ACC_W - SIZE){1'b0}}, prod_cout, prod_out};
    assign sum         = {1'b0, acc_reg} + product_ext;

`ifdef MULT_ACC_SATURATE_EN
    // Once the batch has clamped, carry_reg keeps every later add pinned at the ceiling.
    assign add_value = (sum[ACC_W] || carry_reg) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign add_value = sum[ACC_W-1:0];
`endif

    assign in_ready  = (state_reg == ACCUM) && !clear;
    assign out_valid = (state_reg == DONE);
    assign accept    = in_valid && in_ready;

    assign acc_out    = acc_reg;
    assign sticky_ovf = sticky_reg;
    assign acc_carry  = carry_reg;

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        count_next  = count_reg;
        sticky_next = sticky_reg;
        carry_next  = carry_reg;

        case (state_reg)
            ACCUM: begin
                if (clear) begin
                    acc_next    = '0;
                    count_next  = '0;
                    sticky_next = 1'b0;
                    carry_next  = 1'b0;
                end else if (accept) begin
                    acc_next    = add_value;
                    count_next  = count_reg + 1'b1;
                    sticky_next = sticky_reg | prod_ovf;
                    carry_next  = carry_reg | sum[ACC_W];
                    if (count_reg == LAST_BEAT) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // clear is deliberately ignored here; only the handshake releases the result.
                if (out_ready) begin
                    state_next  = ACCUM;
                    acc_next    = '0;
                    count_next  = '0;
                    sticky_next = 1'b0;
                    carry_next  = 1'b0;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ACCUM;
            acc_reg    <= '0;
            count_reg  <= '0;
            sticky_reg <= 1'b0;
            carry_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            count_reg  <= count_next;
            sticky_reg <= sticky_next;
            carry_reg  <= carry_next;
        end
    end

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed bench for mult_accumulator: three instances cover the default batch, a narrow 6-bit accumulator and COUNT=1.
module tb_mult_accumulator;

    logic clk;
    logic rst;

    // Instance A: SIZE=4, ACC_W=8, COUNT=4
    logic [3:0] a_prod_out;
    logic       a_prod_cout, a_prod_ovf, a_in_valid, a_in_ready, a_clear;
    logic [7:0] a_acc_out;
    logic       a_out_valid, a_out_ready, a_sticky_ovf, a_acc_carry;

    // Instance B: SIZE=4, ACC_W=6, COUNT=4
    logic [3:0] b_prod_out;
    logic       b_prod_cout, b_prod_ovf, b_in_valid, b_in_ready, b_clear;
    logic [5:0] b_acc_out;
    logic       b_out_valid, b_out_ready, b_sticky_ovf, b_acc_carry;

    // Instance C: SIZE=4, ACC_W=8, COUNT=1
    logic [3:0] c_prod_out;
    logic       c_prod_cout, c_prod_ovf, c_in_valid, c_in_ready, c_clear;
    logic [7:0] c_acc_out;
    logic       c_out_valid, c_out_ready, c_sticky_ovf, c_acc_carry;

    int checks;
    int failures;

    mult_accumulator #(.SIZE(4), .ACC_W(8), .COUNT(4)) dut_a (
        .clk(clk), .rst(rst),
        .prod_out(a_prod_out), .prod_cout(a_prod_cout), .prod_ovf(a_prod_ovf),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .clear(a_clear),
        .acc_out(a_acc_out), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .sticky_ovf(a_sticky_ovf), .acc_carry(a_acc_carry)
    );

    mult_accumulator #(.SIZE(4), .ACC_W(6), .COUNT(4)) dut_b (
        .clk(clk), .rst(rst),
        .prod_out(b_prod_out), .prod_cout(b_prod_cout), .prod_ovf(b_prod_ovf),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .clear(b_clear),
        .acc_out(b_acc_out), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sticky_ovf(b_sticky_ovf), .acc_carry(b_acc_carry)
    );

    mult_accumulator #(.SIZE(4), .ACC_W(8), .COUNT(1)) dut_c (
        .clk(clk), .rst(rst),
        .prod_out(c_prod_out), .prod_cout(c_prod_cout), .prod_ovf(c_prod_ovf),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .clear(c_clear),
        .acc_out(c_acc_out), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .sticky_ovf(c_sticky_ovf), .acc_carry(c_acc_carry)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("check %s got=%0h exp=%0h ok", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one product to instance A for exactly one edge.
    task automatic a_beat(input logic [4:0] v, input logic ovf);
        a_prod_out  = v[3:0];
        a_prod_cout = v[4];
        a_prod_ovf  = ovf;
        a_in_valid  = 1'b1;
        tick();
        a_in_valid  = 1'b0;
        a_prod_ovf  = 1'b0;
    endtask

    task automatic b_beat(input logic [4:0] v);
        b_prod_out  = v[3:0];
        b_prod_cout = v[4];
        b_in_valid  = 1'b1;
        tick();
        b_in_valid  = 1'b0;
    endtask

    logic [5:0] exp_b3;
    logic [5:0] exp_b4;

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        a_prod_out = '0; a_prod_cout = 0; a_prod_ovf = 0; a_in_valid = 0; a_clear = 0; a_out_ready = 0;
        b_prod_out = '0; b_prod_cout = 0; b_prod_ovf = 0; b_in_valid = 0; b_clear = 0; b_out_ready = 0;
        c_prod_out = '0; c_prod_cout = 0; c_prod_ovf = 0; c_in_valid = 0; c_clear = 0; c_out_ready = 0;

`ifdef MULT_ACC_SATURATE_EN
        exp_b3 = 6'd63;
        exp_b4 = 6'd63;
`else
        exp_b3 = 6'd29;
        exp_b4 = 6'd60;
`endif

        tick();
        tick();
        check("rst_acc", 32'(a_acc_out), 32'h0);
        check("rst_out_valid", 32'(a_out_valid), 32'h0);
        check("rst_sticky", 32'(a_sticky_ovf), 32'h0);
        check("rst_carry", 32'(a_acc_carry), 32'h0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(a_in_ready), 32'h1);

        // Test 1: 3+5+7+9 = 0x18
        a_beat(5'd3, 1'b0);
        a_beat(5'd5, 1'b0);
        a_beat(5'd7, 1'b0);
        check("t1_not_done_after_3", 32'(a_out_valid), 32'h0);
        check("t1_partial_acc", 32'(a_acc_out), 32'd15);
        a_beat(5'd9, 1'b0);
        check("t1_out_valid", 32'(a_out_valid), 32'h1);
        check("t1_acc", 32'(a_acc_out), 32'h18);
        check("t1_sticky", 32'(a_sticky_ovf), 32'h0);
        check("t1_carry", 32'(a_acc_carry), 32'h0);
        check("t1_in_ready_done", 32'(a_in_ready), 32'h0);
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_prod_out  = 4'd6;
        tick();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b0;
        check("t1_after_hs_valid", 32'(a_out_valid), 32'h0);
        check("t1_after_hs_acc", 32'(a_acc_out), 32'h0);
        check("t1_after_hs_in_ready", 32'(a_in_ready), 32'h1);

        // Test 2: ovf on beat 2 only, consumer stalls 5 cycles with input pressure
        a_beat(5'd1, 1'b0);
        a_beat(5'd1, 1'b1);
        check("t2_sticky_mid", 32'(a_sticky_ovf), 32'h1);
        a_beat(5'd1, 1'b0);
        a_beat(5'd1, 1'b0);
        a_in_valid = 1'b1;
        a_prod_out = 4'd8;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_hold%0d_valid", i), 32'(a_out_valid), 32'h1);
            check($sformatf("t2_hold%0d_acc", i), 32'(a_acc_out), 32'd4);
            check($sformatf("t2_hold%0d_sticky", i), 32'(a_sticky_ovf), 32'h1);
            check($sformatf("t2_hold%0d_in_ready", i), 32'(a_in_ready), 32'h0);
            tick();
        end
        a_in_valid = 1'b0;
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        check("t2_clear_in_done_ignored", 32'(a_acc_out), 32'd4);
        check("t2_clear_in_done_valid", 32'(a_out_valid), 32'h1);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check("t2_release_sticky", 32'(a_sticky_ovf), 32'h0);

        // Test 4: clear together with in_valid after 2 beats
        a_beat(5'd2, 1'b1);
        a_beat(5'd3, 1'b0);
        a_clear = 1'b1;
        a_in_valid = 1'b1;
        a_prod_out = 4'd5;
        #1;
        check("t4_in_ready_clear", 32'(a_in_ready), 32'h0);
        tick();
        a_clear = 1'b0;
        a_in_valid = 1'b0;
        check("t4_acc_cleared", 32'(a_acc_out), 32'h0);
        check("t4_sticky_cleared", 32'(a_sticky_ovf), 32'h0);
        a_beat(5'd1, 1'b0);
        a_beat(5'd2, 1'b0);
        a_beat(5'd3, 1'b0);
        check("t4_not_done_after_3", 32'(a_out_valid), 32'h0);
        a_beat(5'd4, 1'b0);
        check("t4_done", 32'(a_out_valid), 32'h1);
        check("t4_acc", 32'(a_acc_out), 32'd10);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;

        // Test 5: async reset mid-batch, then in DONE
        a_beat(5'd5, 1'b1);
        a_beat(5'd6, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t5_mid_acc", 32'(a_acc_out), 32'h0);
        check("t5_mid_sticky", 32'(a_sticky_ovf), 32'h0);
        rst = 1'b0;
        tick();
        a_beat(5'd1, 1'b1);
        a_beat(5'd2, 1'b0);
        a_beat(5'd3, 1'b0);
        a_beat(5'd4, 1'b0);
        check("t5_batch_from_zero", 32'(a_acc_out), 32'd10);
        check("t5_done_valid", 32'(a_out_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("t5_done_rst_valid", 32'(a_out_valid), 32'h0);
        check("t5_done_rst_acc", 32'(a_acc_out), 32'h0);
        check("t5_done_rst_sticky", 32'(a_sticky_ovf), 32'h0);
        rst = 1'b0;
        tick();
        check("t5_in_ready_after", 32'(a_in_ready), 32'h1);

        // Test 3: ACC_W=6, four beats of 31
        b_beat(5'd31);
        b_beat(5'd31);
        check("t3_acc_2", 32'(b_acc_out), 32'd62);
        check("t3_carry_2", 32'(b_acc_carry), 32'h0);
        b_beat(5'd31);
        check("t3_acc_3", 32'(b_acc_out), 32'(exp_b3));
        check("t3_carry_3", 32'(b_acc_carry), 32'h1);
        b_beat(5'd31);
        check("t3_acc_4", 32'(b_acc_out), 32'(exp_b4));
        check("t3_carry_4", 32'(b_acc_carry), 32'h1);
        check("t3_done", 32'(b_out_valid), 32'h1);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        check("t3_release_carry", 32'(b_acc_carry), 32'h0);
        check("t3_release_acc", 32'(b_acc_out), 32'h0);

        // Test 6: COUNT=1, continuous input and consumer
        c_prod_out  = 4'd7;
        c_in_valid  = 1'b1;
        c_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t6_cyc%0d_in_ready", i), 32'(c_in_ready), 32'((i % 2) == 0));
            check($sformatf("t6_cyc%0d_out_valid", i), 32'(c_out_valid), 32'((i % 2) == 1));
            if ((i % 2) == 1) begin
                check($sformatf("t6_cyc%0d_acc", i), 32'(c_acc_out), 32'd7);
            end
            tick();
        end
        c_in_valid  = 1'b0;
        c_out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_accumulator.md
MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

Interface
REQ-001 SHALL have parameter SIZE, default 4, the operand/product width of the upstream MULTIPLIER_N_BIT.
REQ-002 SHALL have parameter ACC_W, default 8, the accumulator width, legal range SIZE+1 to 32.
REQ-003 SHALL have parameter COUNT, default 4, the products per batch, legal range 1 to 255.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port prod_out, input, SIZE, the multiplier out bus.
REQ-007 SHALL have port prod_cout, input, 1, the multiplier cout.
REQ-008 SHALL have port prod_ovf, input, 1, the multiplier overflow flag.
REQ-009 SHALL have port in_valid, input, 1; the product inputs are valid.
REQ-010 SHALL have port in_ready, output, 1; the block accepts a product.
REQ-011 SHALL have port clear, input, 1, synchronous batch abort.
REQ-012 SHALL have port acc_out, output, ACC_W, the batch sum.
REQ-013 SHALL have port out_valid, output, 1; acc_out and the flags are final.
REQ-014 SHALL have port out_ready, input, 1; the consumer takes the result.
REQ-015 SHALL have port sticky_ovf, output, 1, the OR of prod_ovf over the accepted beats of the batch.
REQ-016 SHALL have port acc_carry, output, 1, sticky, set when any accumulate step exceeds the ACC_W range.

Function
REQ-017 SHALL use a two-state FSM: ACCUM and DONE.
REQ-018 A product SHALL be accepted on a clock edge where in_valid and in_ready are both high.
REQ-019 in_ready SHALL equal (state==ACCUM) and not clear.
REQ-020 Each accepted product SHALL be the unsigned value {prod_cout, prod_out}, zero-extended to ACC_W+1 bits and added to acc_out.
REQ-021 Without saturation, acc_out SHALL take the low ACC_W bits of the sum, and acc_carry SHALL set if bit ACC_W of the sum is 1.
REQ-022 A beat counter SHALL count accepted products from 0.
REQ-023 On the COUNT-th accept, the FSM SHALL move to DONE and out_valid SHALL go high the next cycle (latency 1 cycle from the last accept).
REQ-024 In DONE, acc_out, sticky_ovf and acc_carry SHALL hold stable while out_valid is high and out_ready is low.
REQ-025 On a DONE edge with out_ready high, the FSM SHALL return to ACCUM, and acc_out, the counter, sticky_ovf and acc_carry SHALL clear to 0.
REQ-026 in_ready SHALL stay low during that DONE-to-ACCUM cycle, so there is no same-cycle restart.
REQ-027 clear high in ACCUM SHALL zero acc_out, the counter and both sticky flags, accept nothing, and stay in ACCUM.
REQ-028 clear in DONE SHALL be ignored.
REQ-029 When clear and in_valid are high together, clear SHALL win and the beat SHALL not be accepted.
REQ-030 With COUNT=1, each accepted product SHALL go straight to DONE.
REQ-031 out_valid SHALL equal (state==DONE).

Reset
REQ-032 rst high SHALL immediately force state to ACCUM and acc_out, the counter, sticky_ovf, acc_carry and out_valid to 0, with in_ready=1 after release.
REQ-033 rst asserted mid-batch or in DONE SHALL discard the partial or pending result with no output handshake.

Configuration
REQ-034 Macro MULT_ACC_SATURATE_EN defined SHALL clamp acc_out to 2^ACC_W-1 when a sum exceeds the ACC_W range, set acc_carry, and keep all later adds in the batch at the clamp.
REQ-035 With MULT_ACC_SATURATE_EN undefined, accumulation SHALL wrap modulo 2^ACC_W per REQ-021 and the saturation logic SHALL be absent.

Verification
REQ-036 Test 1: SIZE=4, ACC_W=8, COUNT=4; accept {cout,out}=3,5,7,9 with prod_ovf=0 -> out_valid one cycle after the 4th accept, acc_out=0x18, sticky_ovf=0, acc_carry=0.
REQ-037 Test 2: same setup, prod_ovf=1 only on beat 2 -> sticky_ovf=1 at DONE; out_ready held low 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-038 Test 3: ACC_W=6, four beats of {1,0xF}=31, macro undefined -> acc_out=60, acc_carry=1; macro defined -> acc_out=63, acc_carry=1.
REQ-039 Test 4: after 2 beats, pulse clear together with in_valid -> beat not accepted, acc_out=0, and 4 more beats are then needed for DONE.
REQ-040 Test 5: assert rst asynchronously mid-batch and in DONE -> all outputs 0 before the next clk edge, next batch sums from 0.
REQ-041 Test 6: COUNT=1, back-to-back in_valid with out_ready=1 -> one result every 2 cycles, in_ready toggling 1,0.
